// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main control FSM.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP, S_ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_REG   = 2'b01;
  localparam logic [1:0] SRCA_SHAMT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_control_alu_dec.sv
// R-type funct decoder: ALU op and operand-A select, plus whether funct is supported.
module mips_alu_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic [1:0] alu_src_a,
  output logic       supported
);

  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_a = SRCA_REG;
    supported = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      FN_SLL: begin
        alu_op    = ALU_SLL;
        alu_src_a = SRCA_SHAMT;
      end
      default: supported = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control: Moore FSM whose outputs decode from the registered
// state, with memory strobes qualified by mem_ready and branch PC write by zero.
module mips_mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int RESET_TO_FETCH = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       illegal
);

  localparam state_t RESET_STATE = (RESET_TO_FETCH != 0) ? S_FETCH : S_FETCH;

  state_t     state_q, state_d;
  logic [2:0] dec_alu_op;
  logic [1:0] dec_src_a;
  logic       dec_ok;

  mips_alu_dec u_alu_dec (
    .funct     (funct),
    .alu_op    (dec_alu_op),
    .alu_src_a (dec_src_a),
    .supported (dec_ok)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = dec_ok ? S_EXEC : S_ILLEGAL;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_REG;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    pc_en      = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_BR;
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = SRCA_REG;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = dec_src_a;
        alu_op    = dec_alu_op;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRCA_REG;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_en     = zero;
      end
      S_ADDIWB: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = PC_JUMP;
        pc_en  = 1'b1;
      end
      S_ILLEGAL: illegal = 1'b1;
      default: ;
    endcase
    // State resets asynchronously, but mem_ready-qualified FETCH strobes still need
    // gating so nothing is requested or written while rst_n is low.
    if (!rst_n) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      pc_en     = 1'b0;
      illegal   = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Randomized and directed bench for mips_mc_control against a per-instruction micro-step model.
module tb_mips_mc_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic       mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg;
  logic [1:0] alu_src_a, alu_src_b, pc_src;
  logic [2:0] alu_op;
  logic       pc_en, illegal;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg;
    logic [1:0] src_a, src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       pc_en, illegal;
  } ctl_t;

  // qual: 0 none, 1 ir_write/pc_en follow mem_ready, 2 mem_write follows mem_ready, 3 pc_en follows zero
  typedef struct {
    ctl_t c;
    bit   waits;
    int   qual;
  } step_t;

  step_t steps[$];
  ctl_t  obs;

  assign obs = {mem_read, mem_write, iord, ir_write, reg_write, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, alu_op, pc_src, pc_en, illegal};

  mips_mc_control #(.RESET_TO_FETCH(1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
    .pc_en(pc_en), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.alu_op = 3'b010;
    return c;
  endfunction

  function automatic ctl_t reset_exp();
    ctl_t c = idle();
    c.src_b = 2'b01;
    return c;
  endfunction

  function automatic bit rtype_known(input logic [5:0] fn, output logic [2:0] aop,
                                     output logic [1:0] sa);
    sa = 2'b01;
    aop = 3'b010;
    case (fn)
      6'h20: aop = 3'b010;
      6'h22: aop = 3'b110;
      6'h24: aop = 3'b000;
      6'h25: aop = 3'b001;
      6'h2A: aop = 3'b111;
      6'h00: begin aop = 3'b100; sa = 2'b10; end
      default: return 1'b0;
    endcase
    return 1'b1;
  endfunction

  function automatic int base_cycles(input logic [5:0] op, input logic [5:0] fn);
    logic [2:0] a;
    logic [1:0] s;
    case (op)
      6'h23: return 5;
      6'h2B, 6'h08: return 4;
      6'h00: return rtype_known(fn, a, s) ? 4 : 3;
      default: return 3;
    endcase
  endfunction

  task automatic push(input ctl_t c, input bit w, input int q);
    step_t s;
    s.c = c; s.waits = w; s.qual = q;
    steps.push_back(s);
  endtask

  task automatic build(input logic [5:0] op, input logic [5:0] fn);
    ctl_t c;
    logic [2:0] aop;
    logic [1:0] sa;
    c = idle(); c.mem_read = 1; c.src_b = 2'b01; push(c, 1, 1);
    c = idle(); c.src_b = 2'b11; push(c, 0, 0);
    case (op)
      6'h23, 6'h2B: begin
        c = idle(); c.src_a = 2'b01; c.src_b = 2'b10; push(c, 0, 0);
        if (op == 6'h23) begin
          c = idle(); c.mem_read = 1; c.iord = 1; push(c, 1, 0);
          c = idle(); c.reg_write = 1; c.mem_to_reg = 1; push(c, 0, 0);
        end else begin
          c = idle(); c.iord = 1; push(c, 1, 2);
        end
      end
      6'h00: begin
        if (rtype_known(fn, aop, sa)) begin
          c = idle(); c.src_a = sa; c.alu_op = aop; push(c, 0, 0);
          c = idle(); c.reg_write = 1; c.reg_dst = 1; push(c, 0, 0);
        end else begin
          c = idle(); c.illegal = 1; push(c, 0, 0);
        end
      end
      6'h04: begin
        c = idle(); c.src_a = 2'b01; c.alu_op = 3'b110; c.pc_src = 2'b01; push(c, 0, 3);
      end
      6'h08: begin
        c = idle(); c.src_a = 2'b01; c.src_b = 2'b10; push(c, 0, 0);
        c = idle(); c.reg_write = 1; push(c, 0, 0);
      end
      6'h02: begin
        c = idle(); c.pc_src = 2'b10; c.pc_en = 1; push(c, 0, 0);
      end
      default: begin
        c = idle(); c.illegal = 1; push(c, 0, 0);
      end
    endcase
  endtask

  task automatic check(input string tag, input ctl_t o, input ctl_t e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %05h expected %05h", tag, o, e);
    end
  endtask

  task automatic check_int(input string tag, input int o, input int e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask

  // stall_n < 0: random mem_ready; else fetch is ready and each waiting step stalls stall_n cycles.
  // zero_mode < 0: random zero. abort_cycle >= 0: drop rst_n after checking that cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int stall_n,
                           input int zero_mode, input int abort_cycle, input string name);
    int cyc = 0, stalls = 0, run = 0;
    step_t s;
    ctl_t e;
    bit rdy, z;
    steps.delete();
    build(op, fn);
    while (steps.size() > 0 && cyc < 200) begin
      s = steps[0];
      @(negedge clk);
      if (s.qual == 1) begin
        opcode = 6'($urandom);
        funct  = 6'($urandom);
      end else begin
        opcode = op;
        funct  = fn;
      end
      if (stall_n < 0)       rdy = (run >= 6) ? 1'b1 : ($urandom_range(0, 3) != 0);
      else if (s.qual == 1)  rdy = 1'b1;
      else if (s.waits)      rdy = (run >= stall_n);
      else                   rdy = 1'($urandom_range(0, 1));
      z = (zero_mode < 0) ? 1'($urandom_range(0, 1)) : (zero_mode != 0);
      mem_ready = rdy;
      zero = z;
      #1;
      e = s.c;
      case (s.qual)
        1: begin e.ir_write = rdy; e.pc_en = rdy; end
        2: e.mem_write = rdy;
        3: e.pc_en = z;
        default: ;
      endcase
      check(name, obs, e);
      if (cyc == abort_cycle) begin
        rst_n = 1'b0;
        #1;
        check({name, "_abort"}, obs, reset_exp());
        return;
      end
      cyc++;
      if (s.waits && !rdy) begin
        stalls++;
        run++;
      end else begin
        void'(steps.pop_front());
        run = 0;
      end
    end
    check_int({name, "_cycles"}, cyc, base_cycles(op, fn) + stalls);
  endtask

  task automatic release_reset();
    mem_ready = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  logic [5:0] fn_list [6];

  initial begin
    logic [5:0] op, fn;
    int k;
    fn_list = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00};
    rst_n = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = '0; funct = '0;
    repeat (2) @(negedge clk);
    #1 check("reset", obs, reset_exp());
    mem_ready = 1'b1;
    #1 check("reset_ready", obs, reset_exp());
    release_reset();

    run_instr(6'h00, 6'h20, 0, 0, -1, "r_add");
    run_instr(6'h23, 6'h11, 3, 0, -1, "lw_stall3");
    run_instr(6'h04, 6'h00, 0, 1, -1, "beq_taken");
    run_instr(6'h04, 6'h00, 0, 0, -1, "beq_not_taken");
    run_instr(6'h00, 6'h00, 0, 0, -1, "sll");
    run_instr(6'h3F, 6'h20, 0, 0, -1, "illegal_op");
    run_instr(6'h00, 6'h03, 0, 0, -1, "illegal_funct");
    run_instr(6'h2B, 6'h00, 0, 0, 3, "sw_abort");
    @(posedge clk);
    @(negedge clk);
    #1 check("sw_abort_held", obs, reset_exp());
    release_reset();
    run_instr(6'h08, 6'h00, 0, 0, -1, "addi");
    run_instr(6'h02, 6'h00, 0, 0, -1, "jump");
    run_instr(6'h2B, 6'h00, 2, 0, -1, "sw_stall2");

    for (int i = 0; i < 150; i++) begin
      k  = $urandom_range(0, 9);
      fn = fn_list[$urandom_range(0, 5)];
      case (k)
        0: op = 6'h23;
        1: op = 6'h2B;
        3: op = 6'h04;
        4: op = 6'h08;
        5: op = 6'h02;
        6: begin op = 6'($urandom); fn = 6'($urandom); end
        7: begin op = 6'h00; fn = 6'($urandom); end
        default: op = 6'h00;
      endcase
      run_instr(op, fn, -1, -1, -1, "rand");
    end

    @(negedge clk);
    mem_ready = 1'b0;
    #1 begin
      ctl_t e = reset_exp();
      e.mem_read = 1'b1;
      check("final_fetch", obs, e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
